// File: rtl/fp_mult_sequencer_if.sv
// Operand, core and result signals of fp_mult_sequencer bundled in one interface.
// slave is the sequencer's view; master is the surrounding environment (producer, core, consumer).
interface fp_mult_sequencer_if #(
   parameter int MBITS = 3,
   parameter int EBITS = 4
);
   localparam int W = MBITS + EBITS + 1;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic         mul_start;
   logic [W-1:0] mul_x;
   logic [W-1:0] mul_y;
   logic [1:0]   mul_state;
   logic [W-1:0] mul_z;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_z;
   logic [2:0]   out_flags;
   logic         err;

   modport slave (
      input  in_valid, in_x, in_y, mul_state, mul_z, out_ready,
      output in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_flags, err
   );

   modport master (
      output in_valid, in_x, in_y, mul_state, mul_z, out_ready,
      input  in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_flags, err
   );
endinterface

// File: rtl/fp_mult_sequencer.sv
// Operand FIFO + issue/collect FSM around the sequential IEEEfpMult core; one multiply in flight.
// Optional watchdog on a hung core is enabled by defining FPSEQ_TIMEOUT_EN.
module fp_mult_sequencer #(
   parameter int MBITS = 3,
   parameter int EBITS = 4,
   parameter int DEPTH = 4,
   parameter int TMO   = 15
) (
   input  logic clock,
   input  logic reset,
   fp_mult_sequencer_if.slave bus
);
   localparam int W  = MBITS + EBITS + 1;
   localparam int AW = $clog2(DEPTH);
   // A misconfigured instance never accepts operands.
   localparam bit CFG_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (TMO >= 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_CAPT, S_HOLD} state_t;

   state_t        state_q, state_d;
   logic          load;
   logic [W-1:0]  fifo_x [DEPTH];
   logic [W-1:0]  fifo_y [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop;
   logic [EBITS-1:0] z_exp;
   logic [MBITS-1:0] z_man;
   logic [2:0]       z_flags;

   assign full         = (count == (AW+1)'(DEPTH));
   assign bus.in_ready = !full && CFG_OK;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = (state_q == S_ISSUE);

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_x[wr_ptr] <= bus.in_x;
         fifo_y[wr_ptr] <= bus.in_y;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Class of the core result, taken at capture time.
   assign z_exp   = bus.mul_z[W-2:MBITS];
   assign z_man   = bus.mul_z[MBITS-1:0];
   assign z_flags = {(&z_exp) && (|z_man), (&z_exp) && !(|z_man), z_exp == '0};

`ifdef FPSEQ_TIMEOUT_EN
   localparam int TW = ($clog2(TMO + 1) > 4) ? $clog2(TMO + 1) : 4;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_fire;
`endif

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
`ifdef FPSEQ_TIMEOUT_EN
      tmo_fire = 1'b0;
`endif
      case (state_q)
         // Waiting for an idle core also shields us from a result still in flight across reset.
         S_IDLE:  if (count != '0 && bus.mul_state == 2'd0) begin
                     state_d = S_ISSUE;
                     load    = 1'b1;
                  end
         S_ISSUE: state_d = S_BUSY;
         S_BUSY:  if (bus.mul_state == 2'd2) begin
                     state_d = S_CAPT;
                  end
`ifdef FPSEQ_TIMEOUT_EN
                  else if (tmo_cnt == TW'(TMO - 1)) begin
                     state_d  = S_IDLE;
                     tmo_fire = 1'b1;
                  end
`endif
         S_CAPT:  state_d = S_HOLD;
         S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         bus.mul_start <= 1'b0;
         bus.mul_x     <= '0;
         bus.mul_y     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_z     <= '0;
         bus.out_flags <= '0;
      end else begin
         state_q       <= state_d;
         bus.mul_start <= (state_d == S_ISSUE);
         if (load) begin
            bus.mul_x <= fifo_x[rd_ptr];
            bus.mul_y <= fifo_y[rd_ptr];
         end
         if (state_q == S_CAPT) begin
            bus.out_z     <= bus.mul_z;
            bus.out_flags <= z_flags;
            bus.out_valid <= 1'b1;
         end else if (state_q == S_HOLD && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

`ifdef FPSEQ_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt <= '0;
         bus.err <= 1'b0;
      end else begin
         if (state_q == S_ISSUE)     tmo_cnt <= '0;
         else if (state_q == S_BUSY) tmo_cnt <= tmo_cnt + TW'(1);
         if (tmo_fire) bus.err <= 1'b1;
      end
   end
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Bench for fp_mult_sequencer: behavioural core stand-in, queue-based reference model, random + directed traffic.
module tb_fp_mult_sequencer;
   localparam int MBITS = 3;
   localparam int EBITS = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 15;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   starts = 0;
   int   results = 0;
   int   last_start = 0;
   int   err_cyc = 0;
   bit   err_seen = 0;
   bit   stuck = 0;
   bit   rand_lat = 0;
   int   core_lat = 1;

   logic [15:0] push_q[$];
   logic [7:0]  res_q[$];
   bit          hold_prev = 0;
   logic [7:0]  prev_z = 8'h00;

   fp_mult_sequencer_if #(.MBITS(MBITS), .EBITS(EBITS)) bus ();

   fp_mult_sequencer #(.MBITS(MBITS), .EBITS(EBITS), .DEPTH(DEPTH), .TMO(TMO)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference float multiply: truncating, subnormals flushed to zero, canonical NaN 0x7F.
   function automatic logic [7:0] fpmul(input logic [7:0] a, input logic [7:0] b);
      int ea, eb, ma, mb, p, e, m;
      logic s;
      bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      ea = int'(a[6:3]); eb = int'(b[6:3]);
      ma = int'(a[2:0]); mb = int'(b[2:0]);
      s  = a[7] ^ b[7];
      nan_a = (ea == 15) && (ma != 0);  nan_b = (eb == 15) && (mb != 0);
      inf_a = (ea == 15) && (ma == 0);  inf_b = (eb == 15) && (mb == 0);
      zero_a = (ea == 0);               zero_b = (eb == 0);
      if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return 8'h7F;
      if (inf_a || inf_b) return {s, 7'h78};
      if (zero_a || zero_b) return {s, 7'h00};
      p = (8 + ma) * (8 + mb);
      e = ea + eb - 7;
      if (p >= 128) begin
         e = e + 1;
         p = p / 2;
      end
      m = (p - 64) / 8;
      if (e >= 15) return {s, 7'h78};
      if (e <= 0)  return {s, 7'h00};
      return {s, e[3:0], m[2:0]};
   endfunction

   function automatic logic [2:0] fpclass(input logic [7:0] z);
      int e, m;
      e = int'(z[6:3]);
      m = int'(z[2:0]);
      return {(e == 15) && (m != 0), (e == 15) && (m == 0), e == 0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s %s (cycle %0d)", name, what, cyc);
   endtask

   // Behavioural core stand-in: start -> computing (core_lat cycles) -> postprocess (writes z) -> idle.
   logic [1:0] c_state = 2'd0;
   int         c_cnt = 0;
   logic [7:0] c_res = 8'h00;
   logic [7:0] c_z = 8'h00;
   assign bus.mul_state = c_state;
   assign bus.mul_z     = c_z;

   always @(posedge clk) begin
      case (c_state)
         2'd0: if (bus.mul_start === 1'b1) begin
                  c_res   <= fpmul(bus.mul_x, bus.mul_y);
                  c_cnt   <= rand_lat ? int'($urandom_range(0, 3)) : core_lat - 1;
                  c_state <= 2'd1;
               end
         2'd1: if (!stuck) begin
                  if (c_cnt == 0) c_state <= 2'd2;
                  else            c_cnt   <= c_cnt - 1;
               end
         default: begin
                  c_z     <= c_res;
                  c_state <= 2'd0;
               end
      endcase
   end

   // Scoreboard: events seen at a negedge take effect at the following posedge.
   initial begin
      logic [15:0] op;
      forever begin
         @(negedge clk);
         if (reset) begin
            push_q.delete();
            res_q.delete();
            hold_prev = 0;
            err_seen  = 0;
         end else begin
            chk("in_ready", bus.in_ready, push_q.size() < DEPTH);
            if (bus.mul_start) begin
               starts++;
               last_start = cyc;
               chk("start_core_idle", bus.mul_state, 0);
               if (push_q.size() == 0) fail_now("start_spurious", "actual=start required=no queued operands");
               else begin
                  op = push_q.pop_front();
                  chk("mul_x", bus.mul_x, op[15:8]);
                  chk("mul_y", bus.mul_y, op[7:0]);
                  res_q.push_back(fpmul(op[15:8], op[7:0]));
               end
            end
`ifdef FPSEQ_TIMEOUT_EN
            if (bus.err && !err_seen) begin
               err_seen = 1;
               err_cyc  = cyc;
               if (res_q.size() > 0) res_q.delete(0);
            end
            chk("err", bus.err, err_seen);
`else
            chk("err", bus.err, 0);
`endif
            if (hold_prev) begin
               chk("hold_valid", bus.out_valid, 1);
               chk("hold_z", bus.out_z, prev_z);
            end
            if (bus.out_valid) begin
               if (res_q.size() == 0) fail_now("out_unexpected", "actual=valid required=no pending result");
               else begin
                  chk("out_z", bus.out_z, res_q[0]);
                  chk("out_flags", bus.out_flags, fpclass(res_q[0]));
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               if (res_q.size() > 0) res_q.delete(0);
               results++;
               hold_prev = 0;
            end else begin
               hold_prev = bus.out_valid;
            end
            prev_z = bus.out_z;
            if (bus.in_valid && bus.in_ready) push_q.push_back({bus.in_x, bus.in_y});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Call at posedge+1. Returns the index of the accepting edge.
   task automatic push(input logic [7:0] x, input logic [7:0] y, output int e);
      e = -1;
      bus.in_valid = 1'b1;
      bus.in_x = x;
      bus.in_y = y;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            e = cyc;
            break;
         end
      end
      bus.in_valid = 1'b0;
      if (e < 0) fail_now("push_timeout", "actual=in_ready low required=accept within 300 cycles");
   endtask

   task automatic wait_valid(output logic [7:0] z, output logic [2:0] f, output int t);
      t = -1; z = 8'h00; f = 3'b000;
      @(posedge clk);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            z = bus.out_z; f = bus.out_flags; t = cyc;
            break;
         end
      end
      if (t < 0) fail_now("valid_timeout", "actual=out_valid low required=result within 200 cycles");
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (push_q.size() == 0 && res_q.size() == 0 && !bus.out_valid) begin
            done = 1;
            break;
         end
      end
      chk("drain", done, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int e, t1, t2, s0, r0;
      logic [7:0] z, z0;
      logic [2:0] f;
      bit rand_done;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_x = 8'h00; bus.in_y = 8'h00; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_mul_x", bus.mul_x, 0);
      chk("rst_mul_y", bus.mul_y, 0);
      chk("rst_out_z", bus.out_z, 0);
      chk("rst_out_flags", bus.out_flags, 0);
      chk("rst_err", bus.err, 0);

      chk("model_1x1", fpmul(8'h38, 8'h38), 8'h38);
      chk("model_15x15", fpmul(8'h3C, 8'h3C), 8'h41);
      chk("model_sign", fpmul(8'hB8, 8'h38), 8'hB8);
      chk("model_infx0", fpmul(8'h78, 8'h00), 8'h7F);
      chk("model_ovf", fpmul(8'h77, 8'h77), 8'h78);
      chk("model_cls_nan", fpclass(8'h7F), 3'b100);
      chk("model_cls_inf", fpclass(8'h78), 3'b010);
      chk("model_cls_zero", fpclass(8'h80), 3'b001);

      // 1.0 * 1.0 and first-result latency
      step();
      bus.out_ready = 1'b1;
      push(8'h38, 8'h38, e);
      wait_valid(z, f, t1);
      chk("lat", t1 - e, 5);
      chk("t1_z", z, 8'h38);
      chk("t1_flags", f, 3'b000);

      // 1.5*1.5 then -1*1, back-to-back throughput
      s0 = starts;
      step();
      push(8'h3C, 8'h3C, e);
      push(8'hB8, 8'h38, e);
      wait_valid(z, f, t1);
      chk("t2_z0", z, 8'h41);
      wait_valid(z, f, t2);
      chk("t2_z1", z, 8'hB8);
      chk("t2_period", t2 - t1, 6);
      wait_drain();
      chk("t2_starts", starts - s0, 2);

      // Special values
      step();
      push(8'h78, 8'h00, e);
      wait_valid(z, f, t1);
      chk("t3_nan_z", z, 8'h7F);
      chk("t3_nan_f", f, 3'b100);
      step();
      push(8'h77, 8'h77, e);
      wait_valid(z, f, t1);
      chk("t3_inf_z", z, 8'h78);
      chk("t3_inf_f", f, 3'b010);

      // Fill with consumer stalled, then drain in order
      step();
      bus.out_ready = 1'b0;
      r0 = results;
      for (int i = 0; i < DEPTH + 1; i++) push(8'h38 + 8'(i), 8'h40 - 8'(i), e);
      @(negedge clk);
      chk("t4_full", bus.in_ready, 0);
      wait_valid(z0, f, t1);
      repeat (8) begin
         @(negedge clk);
         chk("t4_held_z", bus.out_z, z0);
         chk("t4_held_v", bus.out_valid, 1);
      end
      step();
      bus.out_ready = 1'b1;
      wait_drain();
      chk("t4_count", results - r0, DEPTH + 1);

      // Reset while the core is computing
      core_lat = 3;
      step();
      push(8'h3C, 8'h3C, e);
      t1 = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.mul_state == 2'd1) begin t1 = k; break; end
      end
      chk("t5_core_busy_seen", t1 >= 0, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t5_in_ready", bus.in_ready, 1);
      chk("t5_out_valid", bus.out_valid, 0);
      chk("t5_core_still_busy", bus.mul_state != 2'd0, 1);
      core_lat = 1;
      step();
      push(8'h38, 8'h3C, e);
      wait_valid(z, f, t1);
      chk("t5_z", z, 8'h3C);
      wait_drain();

`ifdef FPSEQ_TIMEOUT_EN
      // Hung core trips the watchdog
      stuck = 1;
      step();
      push(8'h38, 8'h38, e);
      t1 = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.err) begin t1 = k; break; end
      end
      chk("t6_err", bus.err, 1);
      chk("t6_err_time", err_cyc - last_start, TMO + 1);
      chk("t6_no_out", bus.out_valid, 0);
      stuck = 0;
      step();
      push(8'h3C, 8'h38, e);
      wait_valid(z, f, t1);
      chk("t6_recover_z", z, 8'h3C);
      chk("t6_err_sticky", bus.err, 1);
      wait_drain();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_err_clear", bus.err, 0);
`endif

      // Random traffic with random core latency and consumer stalls
      rand_lat = 1;
      rand_done = 0;
      step();
      fork
         begin
            int pe;
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 3)) step();
               push(8'($urandom), 8'($urandom), pe);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               step();
               bus.out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      step();
      bus.out_ready = 1'b1;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
